// File: rtl/inst_dispatcher_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_dispatcher_if : fetch-port handshake between issuer and ctrl    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface inst_dispatcher_if #(
    parameter int INST_WIDTH = 27
);
    logic [INST_WIDTH-1:0] inst;
    logic                  inst_valid;
    logic                  ctrl_ready;
    logic                  ctrl_done;

    modport master (output inst, output inst_valid, input ctrl_ready, input ctrl_done);
    modport slave  (input inst, input inst_valid, output ctrl_ready, output ctrl_done);
endinterface
`default_nettype wire

// File: rtl/inst_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_dispatcher : host FIFO + IDLE/ISSUE/WAIT issuer with watchdog   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module inst_dispatcher #(
    parameter int INST_WIDTH = 27,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       host_wr_en,
    input  logic [INST_WIDTH-1:0]      host_wr_data,
    output logic                       host_full,
    output logic [$clog2(DEPTH):0]     fifo_level,
    input  logic                       run,
    input  logic                       clr_status,
    inst_dispatcher_if.master          fetch,
    output logic                       busy,
    output logic [CNT_WIDTH-1:0]       issued_cnt,
    output logic [CNT_WIDTH-1:0]       done_cnt,
    output logic                       overflow,
    output logic                       timeout
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [INST_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [WD_W-1:0]       wdog;
    logic                  push, pop, handshake, done_hit, wd_expire;

    assign push      = host_wr_en && !host_full;
    assign host_full = (fifo_level == LVL_W'(DEPTH));
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        handshake = 1'b0;
        done_hit  = 1'b0;
        wd_expire = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run && fifo_level != '0) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fetch.ctrl_ready && fetch.inst_valid) begin
                    handshake = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion on the expiry cycle still counts as a completion.
                if (fetch.ctrl_done) begin
                    done_hit  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (wdog == WD_LAST) begin
                    wd_expire = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host_wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch.inst       <= '0;
            fetch.inst_valid <= 1'b0;
            wdog             <= '0;
        end else begin
            if (pop) begin
                fetch.inst       <= mem[rd_ptr];
                fetch.inst_valid <= 1'b1;
            end else if (handshake) begin
                fetch.inst_valid <= 1'b0;
            end
            if (handshake)             wdog <= '0;
            else if (state == ST_WAIT) wdog <= wdog + WD_W'(1);
        end
    end

    // Clearing wins over any same-cycle increment or sticky set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issued_cnt <= '0;
            done_cnt   <= '0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else if (clr_status) begin
            issued_cnt <= '0;
            done_cnt   <= '0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if (handshake)               issued_cnt <= issued_cnt + CNT_WIDTH'(1);
            if (done_hit)                done_cnt   <= done_cnt + CNT_WIDTH'(1);
            if (host_wr_en && host_full) overflow   <= 1'b1;
            if (wd_expire)               timeout    <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_inst_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inst_dispatcher : scoreboard bench for inst_dispatcher            |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_inst_dispatcher;
    localparam int W  = 27;
    localparam int TO = 4096;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        host_wr_en = 1'b0;
    logic [W-1:0] host_wr_data = '0;
    logic        host_full;
    logic [3:0]  fifo_level;
    logic        run = 1'b0;
    logic        clr_status = 1'b0;
    logic        busy;
    logic [15:0] issued_cnt, done_cnt;
    logic        overflow, timeout;

    inst_dispatcher_if #(.INST_WIDTH(W)) fif ();

    inst_dispatcher dut (
        .clk(clk), .rstn(rstn),
        .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
        .host_full(host_full), .fifo_level(fifo_level),
        .run(run), .clr_status(clr_status),
        .fetch(fif),
        .busy(busy), .issued_cnt(issued_cnt), .done_cnt(done_cnt),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_issued = '0;
    logic [15:0]  exp_done   = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every handshake must present the oldest accepted write.
    logic         prev_v = 1'b0;
    logic [W-1:0] held   = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_v = 1'b0;
        end else begin
            if (fif.inst_valid && prev_v) check("inst_stable", fif.inst, held);
            if (fif.inst_valid && fif.ctrl_ready) begin
                if (exp_q.size() == 0) check("unexpected_issue", fif.inst_valid, 0);
                else                   check("inst_order", fif.inst, exp_q.pop_front());
            end
            prev_v = fif.inst_valid;
            held   = fif.inst;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        host_wr_en   = 1'b1;
        host_wr_data = d;
        exp_q.push_back(d);
        tick();
        host_wr_en   = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!fif.inst_valid && n < 20) begin
            tick();
            n++;
        end
        check("valid_wait", fif.inst_valid, 1);
    endtask

    task automatic handshake(input int dly);
        repeat (dly) tick();
        fif.ctrl_ready = 1'b1;
        tick();
        fif.ctrl_ready = 1'b0;
        exp_issued++;
        check("valid_drop", fif.inst_valid, 0);
        check("issued_cnt", issued_cnt, exp_issued);
    endtask

    task automatic complete(input int dly);
        repeat (dly) tick();
        fif.ctrl_done = 1'b1;
        tick();
        fif.ctrl_done = 1'b0;
        exp_done++;
        check("done_cnt", done_cnt, exp_done);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        fif.ctrl_ready = 1'b0;
        fif.ctrl_done  = 1'b0;
        repeat (2) tick();
        check("rst_inst", fif.inst, 0);
        check("rst_valid", fif.inst_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_full", host_full, 0);
        rstn = 1'b1;
        tick();
        check("rst_busy", busy, 0);
        check("rst_cnts", {issued_cnt, done_cnt, overflow, timeout}, 0);

        // Single issue with latency checks
        run = 1'b1;
        push(27'h6123000);
        check("lvl_t1", fifo_level, 1);
        check("valid_t1", fif.inst_valid, 0);
        tick();
        check("valid_t2", fif.inst_valid, 1);
        check("inst_t2", fif.inst, 27'h6123000);
        handshake(2);
        check("busy_wait", busy, 1);
        complete(10);
        check("lvl_single", fifo_level, 0);

        // Overflow: ninth write dropped, then drain in order
        run = 1'b0;
        for (int i = 0; i < 9; i++) begin
            host_wr_en   = 1'b1;
            host_wr_data = W'(32'h0A00000 + i * 32'h111);
            if (i < 8) exp_q.push_back(host_wr_data);
            tick();
            if (i == 7) begin
                check("full_at_8", host_full, 1);
                check("no_ovf_at_8", overflow, 0);
            end
        end
        host_wr_en = 1'b0;
        check("ovf_set", overflow, 1);
        check("lvl_full", fifo_level, 8);
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_valid();
            handshake(0);
            complete(0);
        end
        check("lvl_drained", fifo_level, 0);
        check("ovf_sticky", overflow, 1);

        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        exp_issued = '0;
        exp_done   = '0;
        check("clr_ovf", overflow, 0);
        check("clr_cnts", {issued_cnt, done_cnt}, 0);

        // Watchdog expiry
        push(27'h1234567);
        push(27'h2345678);
        wait_valid();
        handshake(0);
        repeat (TO - 1) tick();
        check("to_early", timeout, 0);
        check("busy_pre_to", busy, 1);
        tick();
        check("to_set", timeout, 1);
        check("busy_post_to", busy, 0);
        check("done_after_to", done_cnt, exp_done);
        wait_valid();
        handshake(0);
        complete(3);

        // Spurious completions in IDLE, ISSUE and the handshake cycle
        fif.ctrl_done = 1'b1;
        tick();
        fif.ctrl_done = 1'b0;
        check("spur_idle", done_cnt, exp_done);
        push(27'h3456789);
        wait_valid();
        fif.ctrl_done = 1'b1;
        tick();
        fif.ctrl_done = 1'b0;
        check("spur_issue", done_cnt, exp_done);
        check("spur_issue_valid", fif.inst_valid, 1);
        fif.ctrl_ready = 1'b1;
        fif.ctrl_done  = 1'b1;
        tick();
        fif.ctrl_ready = 1'b0;
        fif.ctrl_done  = 1'b0;
        exp_issued++;
        check("spur_hs_done", done_cnt, exp_done);
        check("spur_hs_issued", issued_cnt, exp_issued);
        repeat (3) tick();
        check("spur_still_wait", busy, 1);
        complete(0);

        // Run gating, then simultaneous push and pop
        run = 1'b0;
        for (int i = 0; i < 4; i++) push(W'(32'h4000000 + i * 32'h10101));
        run = 1'b1;
        wait_valid();
        handshake(1);
        run = 1'b0;
        complete(2);
        repeat (5) tick();
        check("gated_valid", fif.inst_valid, 0);
        check("gated_lvl", fifo_level, 3);
        run = 1'b1;
        push(27'h5ABCDEF);
        check("pushpop_lvl", fifo_level, 3);
        for (int i = 0; i < 4; i++) begin
            wait_valid();
            handshake(0);
            complete(1);
        end
        check("drain_lvl", fifo_level, 0);

        // Reset in WAIT with queued entries
        for (int i = 0; i < 5; i++) push(W'(32'h7000000 + i * 32'h3));
        wait_valid();
        handshake(0);
        check("pre_rst_lvl", fifo_level, 4);
        rstn = 1'b0;
        #2;
        check("arst_valid", fif.inst_valid, 0);
        check("arst_inst", fif.inst, 0);
        check("arst_lvl", fifo_level, 0);
        check("arst_full", host_full, 0);
        check("arst_busy", busy, 0);
        check("arst_flags", {issued_cnt, done_cnt, overflow, timeout}, 0);
        tick();
        rstn = 1'b1;
        exp_q.delete();
        exp_issued = '0;
        exp_done   = '0;
        repeat (4) tick();
        check("post_rst_valid", fif.inst_valid, 0);
        check("post_rst_lvl", fifo_level, 0);

        // Clear coinciding with completion
        push(27'h0FEDCBA);
        wait_valid();
        handshake(0);
        repeat (2) tick();
        fif.ctrl_done = 1'b1;
        clr_status    = 1'b1;
        tick();
        fif.ctrl_done = 1'b0;
        clr_status    = 1'b0;
        check("clr_done_cnt", done_cnt, 0);
        check("clr_issued_cnt", issued_cnt, 0);
        check("clr_busy", busy, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
